decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 45 ++++
 rtl/decode_stage_if.sv | 54 +++++
 rtl/decode_fifo.sv | 65 ++++++
 rtl/decode_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types for the decode stage: instruction classes, the decoded micro-op
// and the rotated-immediate expansion helper.
package decode_pkg;

  typedef enum logic [2:0] {
    DP_REG = 3'b000,
    DP_IMM = 3'b001,
    LS_IMM = 3'b010,
    LS_REG = 3'b011,
    BRANCH = 3'b101
  } instr_class_e;

  // Branch target lives beside the uop so its width can follow ADDR_W.
  typedef struct packed {
    logic [3:0]  cond;
    logic [2:0]  cls;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic        setflags;
    logic        use_imm;
    logic        use_rs;
    logic [1:0]  shift;
    logic [4:0]  shift_amt;
    logic [31:0] imm32;
    logic        mem_read;
    logic        mem_write;
    logic        up;
    logic        branch;
    logic        link;
    logic        undef;
  } uop_t;

  // imm8 rotated right by twice the 4-bit rotate field.
  function automatic logic [31:0] rotate_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [31:0] base;
    logic [5:0]  amt;
    base = {24'b0, imm8};
    amt  = {1'b0, rot, 1'b0};
    return (base >> amt) | (base << (6'd32 - amt));
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Input/output handshake bundle of the decode stage; the stage uses the slave
// modport, the instruction source/consumer side uses master.
interface decode_stage_if #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [ADDR_W-1:0] in_pc;

  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_cond;
  logic [2:0]        out_class;
  logic [3:0]        out_opcode;
  logic [3:0]        out_rd;
  logic [3:0]        out_rn;
  logic [3:0]        out_rm;
  logic [3:0]        out_rs;
  logic              out_setflags;
  logic              out_use_imm;
  logic              out_use_rs;
  logic [1:0]        out_shift;
  logic [4:0]        out_shift_amt;
  logic [31:0]       out_imm32;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_up;
  logic              out_branch;
  logic              out_link;
  logic [ADDR_W-1:0] out_target;
  logic              out_undef;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_cond, out_class, out_opcode,
           out_rd, out_rn, out_rm, out_rs, out_setflags, out_use_imm, out_use_rs,
           out_shift, out_shift_amt, out_imm32, out_mem_read, out_mem_write, out_up,
           out_branch, out_link, out_target, out_undef, out_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_cond, out_class, out_opcode,
           out_rd, out_rn, out_rm, out_rs, out_setflags, out_use_imm, out_use_rs,
           out_shift, out_shift_amt, out_imm32, out_mem_read, out_mem_write, out_up,
           out_branch, out_link, out_target, out_undef, out_count
  );

endinterface

// File: rtl/decode_fifo.sv
// DEPTH-entry synchronous queue of decoded uops with occupancy count; reset
// clears every entry, flush only rewinds pointers and count.
module decode_fifo
  import decode_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              flush,
  input  logic              push,
  input  uop_t              push_uop,
  input  logic [ADDR_W-1:0] push_target,
  input  logic              pop,
  output uop_t              head_uop,
  output logic [ADDR_W-1:0] head_target,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  uop_t              uop_mem    [DEPTH];
  logic [ADDR_W-1:0] target_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        uop_mem[i]    <= '0;
        target_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // A push into a full queue is only issued alongside a pop, so the slot
      // being overwritten is the one leaving at this same edge.
      if (push) begin
        uop_mem[wr_ptr_reg]    <= push_uop;
        target_mem[wr_ptr_reg] <= push_target;
        wr_ptr_reg             <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_uop    = uop_mem[rd_ptr_reg];
  assign head_target = target_mem[rd_ptr_reg];
  assign count       = count_reg;
  assign full        = (count_reg == DEPTH_C);

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: combinational decode into a uop, queued in
// decode_fifo. Define DECODE_STAGE_LDST_EN to decode load/store classes.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  decode_stage_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]       instr;
  uop_t              raw_uop;
  uop_t              dec_uop;
  uop_t              head_uop;
  logic [ADDR_W-1:0] dec_target;
  logic [ADDR_W-1:0] raw_target;
  logic [ADDR_W-1:0] head_target;
  logic [31:0]       br_offset;
  logic              undef;
  logic              push;
  logic              pop;
  logic              full;
  logic              out_valid;
  logic [CNT_W-1:0]  count;

  assign instr     = bus.in_instr;
  assign br_offset = {{6{instr[23]}}, instr[23:0], 2'b00};

  always_comb begin
    raw_uop        = '0;
    raw_target     = '0;
    undef          = 1'b0;
    raw_uop.cond   = instr[31:28];
    raw_uop.cls    = instr[27:25];
    raw_uop.opcode = instr[24:21];
    raw_uop.rd     = instr[15:12];
    raw_uop.rn     = instr[19:16];
    raw_uop.rm     = instr[3:0];
    raw_uop.rs     = instr[11:8];

    case (instr[27:25])
      DP_REG: begin
        raw_uop.setflags  = instr[20];
        raw_uop.use_rs    = instr[4];
        raw_uop.shift     = instr[6:5];
        raw_uop.shift_amt = instr[4] ? 5'd0 : instr[11:7];
      end
      DP_IMM: begin
        raw_uop.setflags = instr[20];
        raw_uop.use_imm  = 1'b1;
        raw_uop.imm32    = rotate_imm(instr[7:0], instr[11:8]);
      end
`ifdef DECODE_STAGE_LDST_EN
      LS_IMM: begin
        raw_uop.use_imm   = 1'b1;
        raw_uop.imm32     = {20'b0, instr[11:0]};
        raw_uop.mem_read  = instr[20];
        raw_uop.mem_write = !instr[20];
        raw_uop.up        = instr[23];
      end
      LS_REG: begin
        if (instr[4]) begin
          undef = 1'b1;
        end else begin
          raw_uop.shift     = instr[6:5];
          raw_uop.shift_amt = instr[11:7];
          raw_uop.mem_read  = instr[20];
          raw_uop.mem_write = !instr[20];
          raw_uop.up        = instr[23];
        end
      end
`else
      LS_IMM, LS_REG: undef = 1'b1;
`endif
      BRANCH: begin
        raw_uop.branch = 1'b1;
        raw_uop.link   = instr[24];
        raw_target     = bus.in_pc + ADDR_W'(8) + br_offset[ADDR_W-1:0];
      end
      default: undef = 1'b1;
    endcase

    if (instr[31:28] == 4'hF) begin
      undef = 1'b1;
    end
  end

  // Undefined encodings keep only the raw register/opcode fields.
  always_comb begin
    dec_uop    = raw_uop;
    dec_target = raw_target;
    if (undef) begin
      dec_uop        = '0;
      dec_uop.cond   = raw_uop.cond;
      dec_uop.cls    = raw_uop.cls;
      dec_uop.opcode = raw_uop.opcode;
      dec_uop.rd     = raw_uop.rd;
      dec_uop.rn     = raw_uop.rn;
      dec_uop.rm     = raw_uop.rm;
      dec_uop.rs     = raw_uop.rs;
      dec_uop.undef  = 1'b1;
      dec_target     = '0;
    end
  end

  assign out_valid    = (count != '0);
  assign bus.in_ready = !rst && !flush && (!full || bus.out_ready);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = out_valid && bus.out_ready;

  decode_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .srst        (rst),
    .flush       (flush),
    .push        (push),
    .push_uop    (dec_uop),
    .push_target (dec_target),
    .pop         (pop),
    .head_uop    (head_uop),
    .head_target (head_target),
    .count       (count),
    .full        (full)
  );

  assign bus.out_valid     = out_valid;
  assign bus.out_count     = count;
  assign bus.out_cond      = head_uop.cond;
  assign bus.out_class     = head_uop.cls;
  assign bus.out_opcode    = head_uop.opcode;
  assign bus.out_rd        = head_uop.rd;
  assign bus.out_rn        = head_uop.rn;
  assign bus.out_rm        = head_uop.rm;
  assign bus.out_rs        = head_uop.rs;
  assign bus.out_setflags  = head_uop.setflags;
  assign bus.out_use_imm   = head_uop.use_imm;
  assign bus.out_use_rs    = head_uop.use_rs;
  assign bus.out_shift     = head_uop.shift;
  assign bus.out_shift_amt = head_uop.shift_amt;
  assign bus.out_imm32     = head_uop.imm32;
  assign bus.out_mem_read  = head_uop.mem_read;
  assign bus.out_mem_write = head_uop.mem_write;
  assign bus.out_up        = head_uop.up;
  assign bus.out_branch    = head_uop.branch;
  assign bus.out_link      = head_uop.link;
  assign bus.out_undef     = head_uop.undef;
  assign bus.out_target    = head_target;

endmodule
